// File: rtl/frame_serializer.sv
// Double-buffered frame-to-sample serializer: one active frame streams out while one pending frame waits.
// Optional FRAME_SER_OVR_CNT_EN adds a saturating 8-bit overrun counter output (ovr_cnt).
module frame_serializer #(
  parameter int unsigned N = 256,
  parameter int unsigned W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] frame_in [0:N-1],
  input  logic         frame_valid,
  output logic [W-1:0] sample_out,
  output logic         sample_valid,
  input  logic         sample_ready,
  output logic         sample_last,
  output logic         busy,
  output logic         overrun
`ifdef FRAME_SER_OVR_CNT_EN
  ,
  output logic [7:0]   ovr_cnt
`endif
);

  localparam int unsigned IW = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t        r_state;
  logic [W-1:0]  r_active  [0:N-1];
  logic [W-1:0]  r_pending [0:N-1];
  logic [IW-1:0] r_idx;
  logic          r_pend_full;
  logic          r_overrun;

  logic w_stream;
  logic w_xfer;
  logic w_at_end;
  logic w_frame_end;
  logic w_drop;

  assign w_stream    = (r_state == S_STREAM);
  assign w_xfer      = w_stream & sample_ready;
  assign w_at_end    = (r_idx == LAST_IDX);
  assign w_frame_end = w_xfer & w_at_end;
  // A strobe is dropped only when both buffers are occupied and the active frame is not ending.
  assign w_drop      = w_stream & frame_valid & ~w_frame_end & r_pend_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_pend_full <= 1'b0;
      r_overrun   <= 1'b0;
      for (int i = 0; i < int'(N); i++) begin
        r_active[i]  <= '0;
        r_pending[i] <= '0;
      end
    end else begin
      r_overrun <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (frame_valid) begin
            r_active <= frame_in;
            r_idx    <= '0;
            r_state  <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (w_frame_end) begin
            // Frame end: hand over to pending or a fresh strobe without a bubble.
            r_idx <= '0;
            if (r_pend_full) begin
              r_active <= r_pending;
              if (frame_valid) begin
                r_pending <= frame_in;
              end else begin
                r_pend_full <= 1'b0;
              end
            end else if (frame_valid) begin
              r_active <= frame_in;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            if (w_xfer) begin
              r_idx <= r_idx + IW'(1);
            end
            if (frame_valid) begin
              if (!r_pend_full) begin
                r_pending   <= frame_in;
                r_pend_full <= 1'b1;
              end else begin
                r_overrun <= 1'b1;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef FRAME_SER_OVR_CNT_EN
  logic [7:0] r_ovr_cnt;

  // Saturating count of dropped frames, tracks the overrun pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovr_cnt <= '0;
    end else if (w_drop && (r_ovr_cnt != 8'hFF)) begin
      r_ovr_cnt <= r_ovr_cnt + 8'd1;
    end
  end

  assign ovr_cnt = r_ovr_cnt;
`endif

  assign sample_valid = w_stream;
  assign busy         = w_stream;
  assign sample_out   = w_stream ? r_active[r_idx] : '0;
  assign sample_last  = w_stream & w_at_end;
  assign overrun      = r_overrun;

endmodule
